// File: rtl/ucsbece154a_rf_pkg.sv
// Shared definitions for the scoreboarded register file: clear-sequencer
// state encoding, default data width and the address-width helper.
package ucsbece154a_rf_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

  // Address width needed to index nregs registers.
  function automatic int aw_of(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/ucsbece154a_rf_clrseq.sv
// Clear sequencer: after reset, or on request while ready, it walks every
// register index once, driving a zero write, then reports ready.
module ucsbece154a_rf_clrseq
  import ucsbece154a_rf_pkg::*;
#(
  parameter int NREGS = 32,
  localparam int AW = aw_of(NREGS)
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          clr,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_a
);

  rf_state_e     state_r, state_s;
  logic [AW-1:0] idx_r, idx_s;

  // State and index registers; reset always restarts the walk from index 0.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_CLEAR;
      idx_r   <= {AW{1'b0}};
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  // Next state: CLEAR advances one index per cycle; a clear request is only honoured from READY.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      ST_CLEAR: begin
        if (idx_r == AW'(NREGS - 1)) begin
          state_s = ST_READY;
          idx_s   = {AW{1'b0}};
        end else begin
          state_s = ST_CLEAR;
          idx_s   = idx_r + AW'(1);
        end
      end
      ST_READY: begin
        if (clr) begin
          state_s = ST_CLEAR;
          idx_s   = {AW{1'b0}};
        end else begin
          state_s = ST_READY;
          idx_s   = idx_r;
        end
      end
      default: begin
        state_s = ST_CLEAR;
        idx_s   = {AW{1'b0}};
      end
    endcase
  end

  assign ready  = (state_r == ST_READY);
  assign clr_we = (state_r == ST_CLEAR);
  assign clr_a  = idx_r;

endmodule

// File: rtl/ucsbece154a_rf_sb.sv
// Register file with per-register busy scoreboard and hardware clear.
// Optional macro UCSBECE154A_RF_BYPASS_EN adds same-cycle write-through
// on the read ports; without it reads see storage contents only.
module ucsbece154a_rf_sb
  import ucsbece154a_rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = aw_of(NREGS)
) (
  input  logic                clk,
  input  logic                rst_ni,
  input  logic                clr_i,
  output logic                ready_o,
  input  logic [NRD*AW-1:0]   ra_i,
  output logic [NRD*XLEN-1:0] rd_o,
  output logic [NRD-1:0]      busy_o,
  input  logic                we_i,
  input  logic [AW-1:0]       wa_i,
  input  logic [XLEN-1:0]     wd_i,
  input  logic                iss_i,
  input  logic [AW-1:0]       iss_a_i
);

  logic            ready_s;
  logic            clr_we_s;
  logic [AW-1:0]   clr_a_s;
  logic            wr_ok_s;
  logic            iss_ok_s;
  logic            mem_we_s;
  logic [AW-1:0]   mem_wa_s;
  logic [XLEN-1:0] mem_wd_s;
  logic [NREGS-1:0] busy_r, busy_s;
  logic [XLEN-1:0] mem_r [NREGS];
  logic [AW-1:0]   ra_k_s;
  logic            byp_k_s;

  ucsbece154a_rf_clrseq #(.NREGS(NREGS)) u_clrseq (
    .clk    (clk),
    .rst_ni (rst_ni),
    .clr    (clr_i),
    .ready  (ready_s),
    .clr_we (clr_we_s),
    .clr_a  (clr_a_s)
  );

  assign ready_o  = ready_s;
  // Register 0 is hard-wired: writes and issues to it never take effect.
  assign wr_ok_s  = ready_s & we_i  & (wa_i    != {AW{1'b0}});
  assign iss_ok_s = ready_s & iss_i & (iss_a_i != {AW{1'b0}});

  // Storage write port: the clear sequencer owns it until ready.
  always_comb begin
    mem_we_s = 1'b0;
    mem_wa_s = wa_i;
    mem_wd_s = wd_i;
    if (clr_we_s) begin
      mem_we_s = 1'b1;
      mem_wa_s = clr_a_s;
      mem_wd_s = {XLEN{1'b0}};
    end else begin
      mem_we_s = wr_ok_s;
      mem_wa_s = wa_i;
      mem_wd_s = wd_i;
    end
  end

  // Storage array; deliberately not reset, the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_wa_s] <= mem_wd_s;
    end
  end

  // Busy next-state: writeback clears, issue sets afterwards so the newer producer wins.
  always_comb begin
    busy_s = busy_r;
    if (!ready_s || clr_i) begin
      busy_s = {NREGS{1'b0}};
    end else begin
      if (wr_ok_s) begin
        busy_s[wa_i] = 1'b0;
      end else begin
        busy_s = busy_s;
      end
      if (iss_ok_s) begin
        busy_s[iss_a_i] = 1'b1;
      end else begin
        busy_s = busy_s;
      end
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_s;
    end
  end

  // Combinational read ports; everything reads zero until the clear completes.
  always_comb begin
    rd_o    = {(NRD*XLEN){1'b0}};
    busy_o  = {NRD{1'b0}};
    ra_k_s  = {AW{1'b0}};
    byp_k_s = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ra_k_s = ra_i[k*AW +: AW];
`ifdef UCSBECE154A_RF_BYPASS_EN
      byp_k_s = wr_ok_s & (wa_i == ra_k_s);
`else
      byp_k_s = 1'b0;
`endif
      if (ready_s && (ra_k_s != {AW{1'b0}})) begin
        rd_o[k*XLEN +: XLEN] = byp_k_s ? wd_i : mem_r[ra_k_s];
        busy_o[k] = (byp_k_s && !(iss_ok_s && (iss_a_i == wa_i))) ? 1'b0 : busy_r[ra_k_s];
      end else begin
        rd_o[k*XLEN +: XLEN] = {XLEN{1'b0}};
        busy_o[k] = 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  // Flag software writing the hard-wired zero register.
  always_ff @(posedge clk) begin
    if (rst_ni && ready_s && we_i && (wa_i == {AW{1'b0}})) begin
      $warning("ucsbece154a_rf_sb: write to x0 ignored");
    end
  end
`endif

endmodule
